// File: rtl/ipf_lcu_feeder.sv
// rtl/ipf_lcu_feeder.sv - streams a 128x128 image LCU by LCU to the IPF with per-LCU parameter sideband
module ipf_lcu_feeder #(
  parameter int IMG_LOG2 = 7,
  parameter int PIX_W    = 8,
  parameter int PAR_W    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              cfg_lcu_size,
  output logic [2*IMG_LOG2-1:0]   img_addr,
  input  logic [PIX_W-1:0]        img_q,
  output logic [2*IMG_LOG2-9:0]   par_addr,
  input  logic [PAR_W-1:0]        par_q,
  output logic                    busy,
  output logic                    in_en,
  output logic [PIX_W-1:0]        din,
  output logic [IMG_LOG2-5:0]     lcu_x,
  output logic [IMG_LOG2-5:0]     lcu_y,
  output logic [1:0]              lcu_size,
  output logic [1:0]              ipf_type,
  output logic [4:0]              ipf_band_pos,
  output logic                    ipf_wo_class,
  output logic [15:0]             ipf_offset,
  output logic                    done
);

  localparam int CW = IMG_LOG2 - 1;
  localparam int LW = IMG_LOG2 - 4;
  localparam int PW = 2 * LW;
  localparam logic [CW:0] S_ONE = {{CW{1'b0}}, 1'b1};
  localparam logic [LW:0] L_ONE = {{LW{1'b0}}, 1'b1};
  localparam logic [PW:0] N_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] N_TWO = {{(PW-1){1'b0}}, 2'b10};

  typedef enum logic [1:0] {IDLE, PFETCH, STREAM, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             drain_q, drain_d;
  logic [1:0]       size_q, size_d;
  logic [CW-1:0]    col_q, col_d, row_q, row_d;
  logic [LW-1:0]    lx_q, lx_d, ly_q, ly_d;
  logic [PW-1:0]    par_addr_q, par_addr_d;
  logic [PAR_W-1:0] shadow_q;
  logic             issue, lcu_first, issue_q, lcu_first_q;
  logic             in_en_q, done_q, done_d;
  logic [PIX_W-1:0] din_q;
  logic [LW-1:0]    lcu_x_q, lcu_y_q;
  logic [1:0]       type_q;
  logic [4:0]       band_q;
  logic             wo_q;
  logic [15:0]      off_q;

  logic [2:0]          s_log2, l_log2;
  logic [CW-1:0]       smax;
  logic [LW-1:0]       lmax;
  logic [PW-1:0]       cur_idx;
  logic [PW:0]         nlcu, next_pf;
  logic [IMG_LOG2-1:0] prow, pcol;
  logic                col_end, row_end, lx_end, ly_end, last_pix;

  always_comb begin
    s_log2   = 3'd4 + {1'b0, size_q};
    l_log2   = 3'(IMG_LOG2) - s_log2;
    smax     = CW'((S_ONE << s_log2) - S_ONE);
    lmax     = LW'((L_ONE << l_log2) - L_ONE);
    nlcu     = N_ONE << {l_log2, 1'b0};
    cur_idx  = (PW'(ly_q) << l_log2) | PW'(lx_q);
    next_pf  = {1'b0, cur_idx} + N_TWO;
    col_end  = (col_q == smax);
    row_end  = (row_q == smax);
    lx_end   = (lx_q == lmax);
    ly_end   = (ly_q == lmax);
    last_pix = col_end && row_end && lx_end && ly_end;
    prow     = (IMG_LOG2'(ly_q) << s_log2) | IMG_LOG2'(row_q);
    pcol     = (IMG_LOG2'(lx_q) << s_log2) | IMG_LOG2'(col_q);
  end

  // par_addr idles at 0 so the first LCU's word is already on par_q during PFETCH.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    size_d     = size_q;
    col_d      = col_q;
    row_d      = row_q;
    lx_d       = lx_q;
    ly_d       = ly_q;
    par_addr_d = par_addr_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    lcu_first  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PFETCH;
          size_d  = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
        end
      end
      PFETCH: begin
        issue      = 1'b1;
        lcu_first  = 1'b1;
        par_addr_d = PW'(1);
        state_d    = STREAM;
      end
      STREAM: begin
        issue     = 1'b1;
        lcu_first = (col_q == '0) && (row_q == '0);
        if (last_pix) begin
          state_d    = DRAIN;
          drain_d    = 1'b0;
          par_addr_d = '0;
        end else if (col_end && row_end && (next_pf < nlcu)) begin
          par_addr_d = next_pf[PW-1:0];
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      col_d = col_q + CW'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + CW'(1);
        if (row_end) begin
          row_d = '0;
          lx_d  = lx_q + LW'(1);
          if (lx_end) begin
            lx_d = '0;
            ly_d = ly_end ? '0 : ly_q + LW'(1);
          end
        end
      end
    end
  end

  // Sideband loads one cycle after an LCU's first address, aligning with that pixel on din.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      size_q      <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      par_addr_q  <= '0;
      shadow_q    <= '0;
      issue_q     <= 1'b0;
      lcu_first_q <= 1'b0;
      in_en_q     <= 1'b0;
      done_q      <= 1'b0;
      din_q       <= '0;
      lcu_x_q     <= '0;
      lcu_y_q     <= '0;
      type_q      <= 2'd0;
      band_q      <= 5'd0;
      wo_q        <= 1'b0;
      off_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      size_q      <= size_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      par_addr_q  <= par_addr_d;
      shadow_q    <= par_q;
      issue_q     <= issue;
      lcu_first_q <= lcu_first;
      in_en_q     <= issue_q;
      done_q      <= done_d;
      din_q       <= img_q;
      if (lcu_first_q) begin
        lcu_x_q <= lx_q;
        lcu_y_q <= ly_q;
        type_q  <= shadow_q[PAR_W-1 -: 2];
        band_q  <= shadow_q[PAR_W-3 -: 5];
        wo_q    <= shadow_q[PAR_W-8];
        off_q   <= shadow_q[PAR_W-9 -: 16];
      end
    end
  end

  assign img_addr     = {prow, pcol};
  assign par_addr     = par_addr_q;
  assign busy         = (state_q != IDLE) || done_q;
  assign in_en        = in_en_q;
  assign din          = din_q;
  assign lcu_x        = lcu_x_q;
  assign lcu_y        = lcu_y_q;
  assign lcu_size     = size_q;
  assign ipf_type     = type_q;
  assign ipf_band_pos = band_q;
  assign ipf_wo_class = wo_q;
  assign ipf_offset   = off_q;
  assign done         = done_q;

endmodule
